// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer and its arbiter.
package stream_mux_pkg;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    // Index width that stays at least one bit wide for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or lowest-index-wins when fixed.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          fixed,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic [PW-1:0]  start;
    logic [2*N-1:0] req2;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic           found;

    assign start = fixed ? '0 : ptr;

    // Doubling the request vector lets a single lowest-bit scan handle the wrap.
    always_comb begin
        req2   = {req, req};
        mask   = '0;
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            mask[i] = (i >= int'(start));
        end
        masked = req2 & mask;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && masked[i]) begin
                found        = 1'b1;
                grant[i % N] = 1'b1;
                idx          = PW'(i % N);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N_CH-to-1 registered stream multiplexer with valid/ready handshakes and
// round-robin or fixed-priority arbitration.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = clog2_min1(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    prio_mode,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [CH_W-1:0]   ptr_q,       ptr_d;

    logic [N_CH-1:0]   grant;
    logic [CH_W-1:0]   grant_idx;
    logic              load_en;
    logic              any_req;
    logic              fixed;

    assign fixed   = (prio_mode_e'(prio_mode) == PRIO_FIXED);
    assign load_en = !out_valid_q || out_ready;
    assign any_req = |in_valid;

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .fixed (fixed),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Nothing is handed out while in reset, so a held request is not lost.
    assign in_ready = (load_en && !rst) ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
                out_ch_d    = grant_idx;
                ptr_d       = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_stream_mux;

    localparam int N = 4;
    localparam int W = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            prio_mode;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    logic [W-1:0]    d [N];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit              m_valid;
    int              m_data;
    int              m_ch;
    int              m_ptr;
    logic [N-1:0]    last_acc;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    end

    stream_mux #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .prio_mode (prio_mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner among current requesters, -1 if none.
    function automatic int pick_winner();
        if (prio_mode) begin
            for (int i = 0; i < N; i++) if (in_valid[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle with the inputs already applied.
    task automatic cycle();
        int           g;
        bit           load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g       = pick_winner();
        load    = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (load) begin
            if (g >= 0) begin
                m_valid = 1; m_data = int'(d[g]); m_ch = g; m_ptr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        last_acc = exp_rdy;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; last_acc = '0;
        rst = 1; prio_mode = 0; out_ready = 1; in_valid = '1;
        for (int i = 0; i < N; i++) d[i] = W'(8'hA0 + i);

        // Reset held with all channels requesting
        repeat (3) cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 0;
        cycle();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_ch", 32'(out_ch), 32'd0);

        // Round-robin sequence 1,2,3,0 follows the first beat on channel 0
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("rr_ch", 32'(out_ch), 32'(k % N));
            check("rr_data", 32'(out_data), 32'(8'hA0 + (k % N)));
        end

        // Fixed priority: channels 1 and 3 request, 1 always wins
        prio_mode = 1; in_valid = 4'b1010; d[1] = 8'h11; d[3] = 8'h33;
        repeat (3) begin
            cycle();
            check("fix_ch", 32'(out_ch), 32'd1);
            check("fix_rdy3", 32'(last_acc[3]), 32'd0);
        end
        prio_mode = 0;
        cycle();
        check("rr_after_fix_ch", 32'(out_ch), 32'd3);

        // Backpressure: channel 2 and channel 0 valid, consumer stalls
        in_valid = 4'b0101; d[2] = 8'h55; d[0] = 8'h0F;
        cycle();
        check("bp_load_ch", 32'(out_ch), 32'd0);
        out_ready = 0;
        repeat (4) begin
            cycle();
            check("bp_hold_data", 32'(out_data), 32'h0F);
            check("bp_no_rdy", 32'(last_acc), 32'd0);
        end
        out_ready = 1;
        cycle();
        check("bp_release_valid", 32'(out_valid), 32'd1);
        check("bp_release_data", 32'(out_data), 32'h55);

        // Sparse traffic: drain, single pulse on channel 3, then channel 0 alone
        in_valid = '0;
        cycle();
        in_valid = 4'b1000; d[3] = 8'h3C;
        cycle();
        check("sp_ch", 32'(out_ch), 32'd3);
        check("sp_data", 32'(out_data), 32'h3C);
        in_valid = '0;
        cycle();
        check("sp_one_cycle", 32'(out_valid), 32'd0);
        check("sp_hold_ch", 32'(out_ch), 32'd3);
        in_valid = 4'b0001; d[0] = 8'h77;
        cycle();
        check("sp_ch0_valid", 32'(out_valid), 32'd1);
        check("sp_ch0", 32'(out_ch), 32'd0);

        // Reset during stall
        in_valid = 4'b0100; d[2] = 8'h99;
        out_ready = 0;
        cycle();
        check("rs_stall_valid", 32'(out_valid), 32'd1);
        rst = 1;
        cycle();
        check("rs_no_rdy", 32'(last_acc), 32'd0);
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_data", 32'(out_data), 32'd0);
        rst = 0; out_ready = 1;

        // Randomized traffic; producers hold requests until accepted
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (last_acc[i] || !in_valid[i] || rst) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    d[i] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) prio_mode = ~prio_mode;
            rst = ($urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
